// File: rtl/requant_output_stage.sv
// Per-channel int32 -> int8 requantization with TFLM rounding, feeding an output FIFO
// with a valid/ready handshake, an almost-full throttle and a sticky overflow flag.
module requant_output_stage #(
    parameter int SIZE         = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                param_load,
    input  logic [32*SIZE-1:0]  quant_mult_in,
    input  logic [6*SIZE-1:0]   quant_shift_in,
    input  logic [7:0]          out_zp_in,
    input  logic [7:0]          act_min_in,
    input  logic [7:0]          act_max_in,
    input  logic [32*SIZE-1:0]  acc_data_in,
    input  logic                acc_valid_i,
    input  logic                tile_calc_over_i,
    output logic [8*SIZE-1:0]   out_data_o,
    output logic                out_last_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                almost_full_o,
    output logic                overflow_err_o,
    input  logic                err_clear
);

    localparam int PW        = $clog2(FIFO_DEPTH);
    localparam int CW        = PW + 1;
    localparam int EW        = 8 * SIZE + 1;
    localparam int AF_THRESH = (FIFO_DEPTH > AFULL_MARGIN) ? FIFO_DEPTH - AFULL_MARGIN : 0;

    localparam logic signed [63:0] I32_MAX64 = 64'sd2147483647;
    localparam logic signed [63:0] I32_MIN64 = -64'sd2147483648;

    logic [32*SIZE-1:0] mult_reg;
    logic [6*SIZE-1:0]  shift_reg;
    logic [7:0]         zp_reg, act_min_reg, act_max_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mult_reg    <= '0;
            shift_reg   <= '0;
            zp_reg      <= '0;
            act_min_reg <= '0;
            act_max_reg <= '0;
        end else if (param_load) begin
            mult_reg    <= quant_mult_in;
            shift_reg   <= quant_shift_in;
            zp_reg      <= out_zp_in;
            act_min_reg <= act_min_in;
            act_max_reg <= act_max_in;
        end
    end

    // Multiplier and output parameters ride along with each row, so a row accepted
    // on a param_load cycle finishes with the parameters it started with.
    logic [32*SIZE-1:0] s1_x_next, s1_x_reg, s1_mult_reg;
    logic [5*SIZE-1:0]  s1_rs_next, s1_rs_reg;
    logic               s1_valid_reg, s1_last_reg;
    logic [7:0]         s1_zp_reg, s1_min_reg, s1_max_reg;

    logic [32*SIZE-1:0] s2_h_next, s2_h_reg;
    logic [5*SIZE-1:0]  s2_rs_reg;
    logic               s2_valid_reg, s2_last_reg;
    logic [7:0]         s2_zp_reg, s2_min_reg, s2_max_reg;

    logic [8*SIZE-1:0]  s3_y;

    genvar gi;
    generate
        for (gi = 0; gi < SIZE; gi++) begin : g_lane
            logic signed [5:0]  shift;
            logic signed [6:0]  neg_shift;
            logic [4:0]         ls;
            logic [4:0]         rs;
            logic signed [63:0] acc_ext;
            logic signed [63:0] shifted;
            logic [31:0]        x;

            always_comb begin
                shift     = shift_reg[6*gi +: 6];
                neg_shift = -{shift[5], shift};
                ls        = (shift > 6'sd0) ? shift[4:0] : 5'd0;
                if (neg_shift > 7'sd31)
                    rs = 5'd31;
                else if (neg_shift > 7'sd0)
                    rs = neg_shift[4:0];
                else
                    rs = 5'd0;
                acc_ext = {{32{acc_data_in[32*gi+31]}}, acc_data_in[32*gi +: 32]};
                shifted = acc_ext <<< ls;
                if (shifted > I32_MAX64)
                    x = 32'h7FFF_FFFF;
                else if (shifted < I32_MIN64)
                    x = 32'h8000_0000;
                else
                    x = shifted[31:0];
            end

            assign s1_x_next[32*gi +: 32] = x;
            assign s1_rs_next[5*gi +: 5]  = rs;

            // Saturating rounding doubling high multiply
            logic signed [63:0] xe, me, prod, nudge, sum, sum_adj;
            logic [31:0]        h;

            always_comb begin
                xe      = {{32{s1_x_reg[32*gi+31]}}, s1_x_reg[32*gi +: 32]};
                me      = {{32{s1_mult_reg[32*gi+31]}}, s1_mult_reg[32*gi +: 32]};
                prod    = xe * me;
                nudge   = prod[63] ? (64'sd1 - 64'sd1073741824) : 64'sd1073741824;
                sum     = prod + nudge;
                // bias negative sums so the arithmetic shift truncates toward zero
                sum_adj = sum[63] ? (sum + 64'sd2147483647) : sum;
                if (s1_x_reg[32*gi +: 32] == 32'h8000_0000 &&
                    s1_mult_reg[32*gi +: 32] == 32'h8000_0000)
                    h = 32'h7FFF_FFFF;
                else
                    h = 32'(sum_adj >>> 31);
            end

            assign s2_h_next[32*gi +: 32] = h;

            logic signed [31:0] hh, hs, rr;
            logic [31:0]        mask, rem, thr;
            logic [4:0]         rsh;
            logic signed [32:0] yy, lo, hi, cl_lo, cl;

            always_comb begin
                hh    = s2_h_reg[32*gi +: 32];
                rsh   = s2_rs_reg[5*gi +: 5];
                mask  = (32'd1 << rsh) - 32'd1;
                rem   = hh & mask;
                thr   = (mask >> 1) + {31'd0, hh[31]};
                hs    = hh >>> rsh;
                rr    = hs + {31'd0, (rem > thr)};
                yy    = {rr[31], rr} + {{25{s2_zp_reg[7]}}, s2_zp_reg};
                lo    = {{25{s2_min_reg[7]}}, s2_min_reg};
                hi    = {{25{s2_max_reg[7]}}, s2_max_reg};
                cl_lo = (yy < lo) ? lo : yy;
                cl    = (cl_lo > hi) ? hi : cl_lo;
            end

            assign s3_y[8*gi +: 8] = 8'(cl);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_last_reg  <= 1'b0;
        end else begin
            s1_valid_reg <= acc_valid_i;
            s1_last_reg  <= acc_valid_i & tile_calc_over_i;
            s2_valid_reg <= s1_valid_reg;
            s2_last_reg  <= s1_last_reg;
        end
    end

    always_ff @(posedge clk) begin
        s1_x_reg    <= s1_x_next;
        s1_rs_reg   <= s1_rs_next;
        s1_mult_reg <= mult_reg;
        s1_zp_reg   <= zp_reg;
        s1_min_reg  <= act_min_reg;
        s1_max_reg  <= act_max_reg;
        s2_h_reg    <= s2_h_next;
        s2_rs_reg   <= s1_rs_reg;
        s2_zp_reg   <= s1_zp_reg;
        s2_min_reg  <= s1_min_reg;
        s2_max_reg  <= s1_max_reg;
    end

    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          push, pop, full, push_ok, overflow;
    logic [1:0]    infl_next;
    logic [CW:0]   occ_next;
    logic          afull_reg, ovf_reg;
    logic [EW-1:0] head;

    always_comb begin
        full       = (count_reg == CW'(FIFO_DEPTH));
        pop        = (count_reg != '0) & out_ready_i;
        push       = s2_valid_reg;
        push_ok    = push & (~full | pop);
        overflow   = push & full & ~pop;
        count_next = count_reg;
        if (push_ok & ~pop)
            count_next = count_reg + CW'(1);
        else if (pop & ~push_ok)
            count_next = count_reg - CW'(1);
        // rows that will sit in S1/S2 after this edge
        infl_next = {1'b0, acc_valid_i} + {1'b0, s1_valid_reg};
        occ_next  = {1'b0, count_next} + (CW+1)'(infl_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            afull_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_next;
            afull_reg <= (occ_next >= (CW+1)'(AF_THRESH));
            if (overflow)
                ovf_reg <= 1'b1;
            else if (err_clear)
                ovf_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr_reg] <= {s3_y, s2_last_reg};
    end

    assign head           = fifo_mem[rd_ptr_reg];
    assign out_valid_o    = (count_reg != '0);
    assign out_data_o     = out_valid_o ? head[EW-1:1] : '0;
    assign out_last_o     = out_valid_o & head[0];
    assign almost_full_o  = afull_reg;
    assign overflow_err_o = ovf_reg;

endmodule

// File: tb/tb_requant_output_stage.sv
// Directed bench for requant_output_stage: arithmetic corner cases, parameter timing,
// backpressure/overflow and asynchronous reset mid-tile.
module tb_requant_output_stage;

    localparam int SIZE = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                param_load;
    logic [32*SIZE-1:0]  quant_mult_in;
    logic [6*SIZE-1:0]   quant_shift_in;
    logic [7:0]          out_zp_in, act_min_in, act_max_in;
    logic [32*SIZE-1:0]  acc_data_in;
    logic                acc_valid_i, tile_calc_over_i;
    logic [8*SIZE-1:0]   out_data_o;
    logic                out_last_o, out_valid_o, out_ready_i;
    logic                almost_full_o, overflow_err_o, err_clear;

    int total = 0;
    int bad   = 0;

    // round-half-away-from-zero of 1024/2^i, then clamped to int8
    logic [7:0] pl_exp [SIZE] = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd64, 8'd32, 8'd16, 8'd8,
                                  8'd4, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};

    requant_output_stage #(
        .SIZE(SIZE),
        .FIFO_DEPTH(8),
        .AFULL_MARGIN(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .param_load(param_load),
        .quant_mult_in(quant_mult_in),
        .quant_shift_in(quant_shift_in),
        .out_zp_in(out_zp_in),
        .act_min_in(act_min_in),
        .act_max_in(act_max_in),
        .acc_data_in(acc_data_in),
        .acc_valid_i(acc_valid_i),
        .tile_calc_over_i(tile_calc_over_i),
        .out_data_o(out_data_o),
        .out_last_o(out_last_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .almost_full_o(almost_full_o),
        .overflow_err_o(overflow_err_o),
        .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [32*SIZE-1:0] rep32(input logic [31:0] v);
        logic [32*SIZE-1:0] r;
        for (int i = 0; i < SIZE; i++) r[32*i +: 32] = v;
        return r;
    endfunction

    function automatic logic [6*SIZE-1:0] rep6(input logic [5:0] v);
        logic [6*SIZE-1:0] r;
        for (int i = 0; i < SIZE; i++) r[6*i +: 6] = v;
        return r;
    endfunction

    function automatic logic [8*SIZE-1:0] rep8(input logic [7:0] v);
        logic [8*SIZE-1:0] r;
        for (int i = 0; i < SIZE; i++) r[8*i +: 8] = v;
        return r;
    endfunction

    task automatic set_params(input logic [31:0] m, input logic [5:0] s, input logic [7:0] zp,
                              input logic [7:0] mn, input logic [7:0] mx);
        quant_mult_in  = rep32(m);
        quant_shift_in = rep6(s);
        out_zp_in      = zp;
        act_min_in     = mn;
        act_max_in     = mx;
    endtask

    task automatic pulse_load();
        param_load = 1'b1;
        @(negedge clk);
        param_load = 1'b0;
    endtask

    // One row through an empty pipeline with ready=1; checks latency, data and last.
    task automatic run_row(input string tag, input logic [32*SIZE-1:0] accv, input logic last,
                           input logic ld, input logic [8*SIZE-1:0] exp);
        int lat;
        acc_data_in      = accv;
        acc_valid_i      = 1'b1;
        tile_calc_over_i = last;
        param_load       = ld;
        @(negedge clk);
        acc_valid_i      = 1'b0;
        tile_calc_over_i = 1'b0;
        param_load       = 1'b0;
        lat = 1;
        while (!out_valid_o && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_lat"}, 128'(lat), 128'(3));
        check_eq({tag, "_data"}, out_data_o, exp);
        check_eq({tag, "_last"}, 128'(out_last_o), 128'(last));
        @(negedge clk);
    endtask

    initial begin
        logic [32*SIZE-1:0] accv;
        logic [8*SIZE-1:0]  expv;
        int                 stale;

        rst = 1'b1;
        param_load = 1'b0;
        quant_mult_in = '0;
        quant_shift_in = '0;
        out_zp_in = '0;
        act_min_in = '0;
        act_max_in = '0;
        acc_data_in = '0;
        acc_valid_i = 1'b0;
        tile_calc_over_i = 1'b0;
        out_ready_i = 1'b1;
        err_clear = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_valid", 128'(out_valid_o), 128'(0));
        check_eq("rst_data", out_data_o, '0);
        check_eq("rst_last", 128'(out_last_o), 128'(0));
        check_eq("rst_afull", 128'(almost_full_o), 128'(0));
        check_eq("rst_ovf", 128'(overflow_err_o), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // basic scale: 100 * 0.5 / 2 - 128 = -103
        set_params(32'h4000_0000, 6'h3F, 8'h80, 8'h80, 8'h7F);
        pulse_load();
        run_row("basic", rep32(32'd100), 1'b1, 1'b0, rep8(8'h99));

        // new params loaded on the same cycle as a row: that row keeps the old ones
        set_params(32'h7FFF_FFFF, 6'h3F, 8'h00, 8'h80, 8'h7F);
        run_row("ld_same_cycle", rep32(32'd100), 1'b0, 1'b1, rep8(8'h99));
        run_row("round_neg", rep32(-32'sd5), 1'b0, 1'b0, rep8(8'hFD));
        run_row("round_pos", rep32(32'd5), 1'b0, 1'b0, rep8(8'h03));

        set_params(32'h8000_0000, 6'h00, 8'h00, 8'h80, 8'h7F);
        pulse_load();
        run_row("srdhm_sat", rep32(32'h8000_0000), 1'b0, 1'b0, rep8(8'h7F));

        // +-2^30 << 2 saturates to int32 max/min; a tiny multiplier then gives +1 / -1
        set_params(32'h0000_0001, 6'h02, 8'h00, 8'h80, 8'h7F);
        pulse_load();
        for (int i = 0; i < SIZE; i++) begin
            accv[32*i +: 32] = (i % 2 == 0) ? 32'h4000_0000 : 32'hC000_0000;
            expv[8*i +: 8]   = (i % 2 == 0) ? 8'h01 : 8'hFF;
        end
        run_row("lshift_sat", accv, 1'b0, 1'b0, expv);

        set_params(32'h4000_0000, 6'h00, 8'h00, 8'h00, 8'h06);
        pulse_load();
        run_row("clamp_hi", rep32(32'd100), 1'b0, 1'b0, rep8(8'h06));
        run_row("clamp_lo", rep32(-32'sd100), 1'b0, 1'b0, rep8(8'h00));

        set_params(32'h7FFF_FFFF, 6'h00, 8'h00, 8'h80, 8'h7F);
        for (int i = 0; i < SIZE; i++) begin
            quant_shift_in[6*i +: 6] = 6'(-i);
            expv[8*i +: 8] = pl_exp[i];
        end
        pulse_load();
        run_row("per_lane", rep32(32'd1024), 1'b1, 1'b0, expv);

        // backpressure: row k gives (100+k)-128
        set_params(32'h4000_0000, 6'h3F, 8'h80, 8'h80, 8'h7F);
        pulse_load();
        check_eq("afull_idle", 128'(almost_full_o), 128'(0));
        out_ready_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            acc_data_in      = rep32(32'(400 + 4 * k));
            acc_valid_i      = 1'b1;
            tile_calc_over_i = (k == 7);
            @(negedge clk);
            check_eq($sformatf("afull_after_row%0d", k), 128'(almost_full_o), 128'(k + 1 >= 4));
        end
        acc_valid_i = 1'b0;
        tile_calc_over_i = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("full_no_ovf", 128'(overflow_err_o), 128'(0));
        check_eq("full_valid", 128'(out_valid_o), 128'(1));
        check_eq("stall_head_a", out_data_o, rep8(8'hE4));

        acc_data_in = rep32(32'd4000);
        acc_valid_i = 1'b1;
        @(negedge clk);
        acc_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("ovf_set", 128'(overflow_err_o), 128'(1));
        check_eq("stall_head_b", out_data_o, rep8(8'hE4));
        check_eq("stall_last", 128'(out_last_o), 128'(0));

        out_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("drain%0d_valid", k), 128'(out_valid_o), 128'(1));
            check_eq($sformatf("drain%0d_data", k), out_data_o, rep8(8'(k - 28)));
            check_eq($sformatf("drain%0d_last", k), 128'(out_last_o), 128'(k == 7));
            @(negedge clk);
        end
        check_eq("drained_empty", 128'(out_valid_o), 128'(0));
        check_eq("ovf_sticky", 128'(overflow_err_o), 128'(1));
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check_eq("ovf_cleared", 128'(overflow_err_o), 128'(0));

        // reset with 3 rows buffered and 2 still in the pipeline
        out_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            acc_data_in = rep32(32'(400 + 4 * k));
            acc_valid_i = 1'b1;
            @(negedge clk);
        end
        acc_valid_i = 1'b0;
        check_eq("pre_rst_valid", 128'(out_valid_o), 128'(1));
        check_eq("pre_rst_afull", 128'(almost_full_o), 128'(1));
        #1 rst = 1'b1;
        #1;
        check_eq("async_rst_valid", 128'(out_valid_o), 128'(0));
        check_eq("async_rst_data", out_data_o, '0);
        check_eq("async_rst_afull", 128'(almost_full_o), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid_o) stale++;
        end
        check_eq("no_stale_rows", 128'(stale), 128'(0));

        out_ready_i = 1'b1;
        set_params(32'h4000_0000, 6'h3F, 8'h80, 8'h80, 8'h7F);
        pulse_load();
        run_row("post_rst_a", rep32(32'd100), 1'b0, 1'b0, rep8(8'h99));
        run_row("post_rst_b", rep32(32'd200), 1'b1, 1'b0, rep8(8'hB2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
